// File: rtl/prod_scheduler.sv
// Round-robin arbiter sharing the wrapper write port between the fibonacci and
// timer producers, with per-source burst quotas, backpressure and stop/drain.
module prod_scheduler #(
  parameter int DATA_W = 16,
  parameter int QW     = 4,
  parameter int CW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              stop,
  input  logic [QW-1:0]     quota_f,
  input  logic [QW-1:0]     quota_t,
  input  logic              buffer_full,
  input  logic              f_valid,
  input  logic [DATA_W-1:0] f_out,
  input  logic              t_valid,
  input  logic [DATA_W-1:0] t_out,
  output logic              f_en,
  output logic              t_en,
  output logic              data_1_en,
  output logic [DATA_W-1:0] data_1,
  output logic [1:0]        grant,
  output logic [CW-1:0]     f_cnt,
  output logic [CW-1:0]     t_cnt,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_F  = 3'd1,
    GNT_T  = 3'd2,
    SWITCH = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic          SRC_F  = 1'b0;
  localparam logic          SRC_T  = 1'b1;
  localparam logic [QW-1:0] Q_ZERO = {QW{1'b0}};
  localparam logic [QW-1:0] Q_ONE  = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};

  state_t        state;
  logic          owner;      // current owner; also the source granted last
  logic [QW-1:0] qlat;
  logic [QW-1:0] burst_cnt;

  logic          active;
  logic          fwd_f;
  logic          fwd_t;
  logic          stray;
  logic          any_q;
  logic          next_src;
  logic [QW-1:0] next_q;
  logic [QW-1:0] burst_next;

  // Forwarding, produce enables and next-grant selection
  always_comb begin
    active     = (state != IDLE);
    fwd_f      = active & f_valid & (owner == SRC_F);
    fwd_t      = active & t_valid & (owner == SRC_T);
    stray      = active & ((f_valid & (owner == SRC_T)) | (t_valid & (owner == SRC_F)));
    burst_next = burst_cnt + QW'(fwd_f | fwd_t);
    // a word arriving now as the last of the burst must not trigger another
    f_en       = (state == GNT_F) & ~buffer_full & ~(f_valid & (burst_cnt == qlat - Q_ONE));
    t_en       = (state == GNT_T) & ~buffer_full & ~(t_valid & (burst_cnt == qlat - Q_ONE));
    data_1_en  = fwd_f | fwd_t;
    data_1     = (owner == SRC_T) ? t_out : f_out;
    any_q      = (quota_f != Q_ZERO) | (quota_t != Q_ZERO);
    if (owner == SRC_T) begin
      next_src = (quota_f != Q_ZERO) ? SRC_F : SRC_T;
    end else begin
      next_src = (quota_t != Q_ZERO) ? SRC_T : SRC_F;
    end
    next_q = (next_src == SRC_T) ? quota_t : quota_f;
    case (state)
      GNT_F:   grant = 2'b01;
      GNT_T:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Scheduler state machine, counters and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= SRC_T;
      qlat      <= Q_ZERO;
      burst_cnt <= Q_ZERO;
      f_cnt     <= C_ZERO;
      t_cnt     <= C_ZERO;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done  <= 1'b0;
      f_cnt <= f_cnt + CW'(fwd_f);
      t_cnt <= t_cnt + CW'(fwd_t);
      err   <= err | stray;
      case (state)
        IDLE: begin
          if (enable && any_q) begin
            f_cnt     <= C_ZERO;
            t_cnt     <= C_ZERO;
            err       <= 1'b0;
            owner     <= next_src;
            qlat      <= next_q;
            burst_cnt <= Q_ZERO;
            state     <= (next_src == SRC_T) ? GNT_T : GNT_F;
          end
        end
        GNT_F, GNT_T: begin
          burst_cnt <= burst_next;
          if (stop) begin
            state <= DRAIN;
          end else if (burst_next == qlat) begin
            state <= SWITCH;
          end
        end
        SWITCH: begin
          if (stop) begin
            state <= DRAIN;
          end else if (enable && any_q) begin
            owner     <= next_src;
            qlat      <= next_q;
            burst_cnt <= Q_ZERO;
            state     <= (next_src == SRC_T) ? GNT_T : GNT_F;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prod_scheduler.sv
// Bench for prod_scheduler: table of quota configurations, hand sequences for
// backpressure/stop/err/reset, and a randomized transaction-level model.
module tb_prod_scheduler;
  localparam int DATA_W = 16;
  localparam int QW     = 4;
  localparam int CW     = 16;
  localparam logic [15:0] F_BASE = 16'h1000;
  localparam logic [15:0] T_BASE = 16'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable, stop, buffer_full, f_valid, t_valid;
  logic [QW-1:0]     quota_f, quota_t;
  logic [DATA_W-1:0] f_out, t_out;
  logic              f_en, t_en, data_1_en, done, err;
  logic [DATA_W-1:0] data_1;
  logic [1:0]        grant;
  logic [CW-1:0]     f_cnt, t_cnt;

  prod_scheduler #(.DATA_W(DATA_W), .QW(QW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .stop(stop),
    .quota_f(quota_f), .quota_t(quota_t), .buffer_full(buffer_full),
    .f_valid(f_valid), .f_out(f_out), .t_valid(t_valid), .t_out(t_out),
    .f_en(f_en), .t_en(t_en), .data_1_en(data_1_en), .data_1(data_1),
    .grant(grant), .f_cnt(f_cnt), .t_cnt(t_cnt), .done(done), .err(err)
  );

  int   tests = 0;
  int   fails = 0;
  int   f_seq, t_seq;
  logic en_f_c, en_t_c;

  typedef struct {
    logic [3:0] qf;
    logic [3:0] qt;
    logic [1:0] g1;
    int         n1;
    logic [1:0] g2;
    int         n2;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Producers answer an enable with a valid word on the following cycle.
  task automatic tick();
    @(negedge clk);
    en_f_c = f_en;
    en_t_c = t_en;
    @(posedge clk);
    #1;
    f_valid = en_f_c;
    t_valid = en_t_c;
    if (en_f_c === 1'b1) begin f_out = F_BASE + 16'(f_seq); f_seq++; end
    if (en_t_c === 1'b1) begin t_out = T_BASE + 16'(t_seq); t_seq++; end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; stop = 1'b0; buffer_full = 1'b0;
    quota_f = 4'd0; quota_t = 4'd0;
    f_valid = 1'b0; t_valid = 1'b0; f_out = 16'h0; t_out = 16'h0;
    tick(); tick();
    f_valid = 1'b0; t_valid = 1'b0;
    f_seq = 0; t_seq = 0;
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (grant != 2'b00) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Counts words forwarded while the current grant holds, plus the switch cycle.
  task automatic count_burst(output int n);
    logic [1:0] g;
    g = grant;
    n = 0;
    for (int i = 0; i < 40 && grant == g; i++) begin
      if (data_1_en) n++;
      tick();
    end
    if (data_1_en) n++;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   n;
    int   qf, qt, rem, mf, mt;
    logic m_src;

    vecs[0] = '{4'd3,  4'd2, 2'b01, 3,  2'b10, 2};
    vecs[1] = '{4'd0,  4'd4, 2'b10, 4,  2'b10, 4};
    vecs[2] = '{4'd5,  4'd0, 2'b01, 5,  2'b01, 5};
    vecs[3] = '{4'd1,  4'd1, 2'b01, 1,  2'b10, 1};
    vecs[4] = '{4'd15, 4'd3, 2'b01, 15, 2'b10, 3};
    vecs[5] = '{4'd0,  4'd0, 2'b00, 0,  2'b00, 0};

    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_en", {30'd0, f_en, t_en}, 32'd0);
    chk("rst_d1en", 32'(data_1_en), 32'd0);
    chk("rst_cnt", {f_cnt, t_cnt}, 32'd0);
    chk("rst_flags", {30'd0, done, err}, 32'd0);

    // Table of quota configurations: first two bursts
    for (int i = 0; i < 6; i++) begin
      do_reset();
      quota_f = vecs[i].qf;
      quota_t = vecs[i].qt;
      enable  = 1'b1;
      #1;
      wait_grant(ok);
      if (vecs[i].g1 == 2'b00) begin
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_en", {30'd0, f_en, t_en}, 32'd0);
      end else begin
        chk("g1", 32'(grant), 32'(vecs[i].g1));
        count_burst(n);
        chk("n1", 32'(n), 32'(vecs[i].n1));
        chk("f_cnt1", 32'(f_cnt), (vecs[i].g1 == 2'b01) ? 32'(vecs[i].n1) : 32'd0);
        chk("t_cnt1", 32'(t_cnt), (vecs[i].g1 == 2'b10) ? 32'(vecs[i].n1) : 32'd0);
        chk("g2", 32'(grant), 32'(vecs[i].g2));
        count_burst(n);
        chk("n2", 32'(n), 32'(vecs[i].n2));
      end
    end

    // Backpressure after the 2nd of 3 fibonacci words
    do_reset();
    quota_f = 4'd3; quota_t = 4'd2; enable = 1'b1; #1;
    wait_grant(ok);
    for (int i = 0; i < 10 && !(data_1_en && f_cnt == 16'd1); i++) tick();
    buffer_full = 1'b1; #1;
    chk("bf_en_low", 32'(f_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bf_hold", {29'd0, grant, f_en}, {29'd0, 2'b01, 1'b0});
    end
    tick();
    buffer_full = 1'b0; #1;
    chk("bf_release_en", 32'(f_en), 32'd1);
    count_burst(n);
    chk("bf_last_words", 32'(n), 32'd1);
    chk("bf_f_cnt", 32'(f_cnt), 32'd3);
    chk("bf_next_grant", 32'(grant), 32'b10);

    // Stop during GNT_T with a word arriving in DRAIN
    do_reset();
    quota_f = 4'd3; quota_t = 4'd4; enable = 1'b1; #1;
    wait_grant(ok);
    for (int i = 0; i < 20 && grant != 2'b10; i++) tick();
    chk("stop_pre_grant", 32'(grant), 32'b10);
    stop = 1'b1; #1;
    tick();
    stop = 1'b0; enable = 1'b0; #1;
    chk("drain_grant", {29'd0, grant, t_en}, 32'd0);
    chk("drain_fwd", 32'(data_1_en), 32'd1);
    chk("drain_data", 32'(data_1), 32'(T_BASE));
    chk("drain_done_early", 32'(done), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("drain_t_cnt", 32'(t_cnt), 32'd1);
    tick();
    chk("done_single", 32'(done), 32'd0);

    // Non-owner valid raises a sticky err, cleared at next session start
    do_reset();
    quota_f = 4'd3; quota_t = 4'd2; enable = 1'b1; #1;
    wait_grant(ok);
    t_valid = 1'b1; #1;
    chk("stray_not_fwd", 32'(data_1_en), 32'd0);
    tick();
    chk("err_set", 32'(err), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 20 && grant != 2'b00; i++) tick();
    tick(); tick();
    chk("err_sticky", {29'd0, grant, err}, 32'd1);
    enable = 1'b1; #1;
    tick();
    chk("err_cleared", 32'(err), 32'd0);
    chk("resume_grant_t", 32'(grant), 32'b10);

    // Reset mid-burst aborts without drain
    do_reset();
    quota_f = 4'd3; quota_t = 4'd2; enable = 1'b1; #1;
    wait_grant(ok);
    tick();
    chk("mid_valid", 32'(f_valid), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_out", {27'd0, grant, f_en, t_en, data_1_en}, 32'd0);
    chk("mid_rst_cnt", {f_cnt, t_cnt}, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_no_done", 32'(done), 32'd0);
    wait_grant(ok);
    chk("mid_first_f", 32'(grant), 32'b01);

    // Randomized runs against a word-sequence model
    for (int it = 0; it < 20; it++) begin
      do_reset();
      qf = $urandom_range(0, 15);
      qt = $urandom_range(0, 15);
      if (qf == 0 && qt == 0) qt = 1;
      quota_f = 4'(qf); quota_t = 4'(qt); enable = 1'b1;
      m_src = (qf != 0) ? 1'b0 : 1'b1;
      rem = m_src ? qt : qf;
      mf = 0; mt = 0;
      for (int c = 0; c < 150; c++) begin
        buffer_full = ($urandom_range(0, 3) == 0);
        #1;
        if (data_1_en) begin
          chk("rand_data", 32'(data_1), m_src ? 32'(T_BASE + 16'(mt)) : 32'(F_BASE + 16'(mf)));
          if (m_src) mt++; else mf++;
          rem--;
          if (rem == 0) begin
            if ((m_src ? qf : qt) != 0) m_src = ~m_src;
            rem = m_src ? qt : qf;
          end
        end
        chk("rand_en_grant", {30'd0, f_en && grant != 2'b01, t_en && grant != 2'b10}, 32'd0);
        tick();
      end
      chk("rand_f_cnt", 32'(f_cnt), 32'(mf));
      chk("rand_t_cnt", 32'(t_cnt), 32'(mt));
      chk("rand_err", 32'(err), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prod_scheduler.md
Name: prod_scheduler

Overview:
- Round-robin scheduler sharing the wrapper write port (data_1_en/data_1) between the fibonacci and timer producers.
- Grants one producer at a time for a programmable burst of words, then hands over to the other.
- Honours buffer_full backpressure and drains cleanly on stop.
- Sits in the clk_1 domain between the producers and the wrapper, replacing the fixed mode mux.

Parameters:
DATA_W, 16, producer/wrapper data width
QW, 4, width of burst quota inputs (max burst 2^QW-1 words)
CW, 16, width of per-source word counters

Ports:
clk  in  1  clock (clk_1 domain)
rst  in  1  synchronous, active-low reset
enable  in  1  level; scheduling allowed while high
stop  in  1  one-cycle pulse; end session and drain
quota_f  in  QW  words per fibonacci burst; 0 = skip source
quota_t  in  QW  words per timer burst; 0 = skip source
buffer_full  in  1  wrapper full flag
f_valid  in  1  fibonacci word valid
f_out  in  DATA_W  fibonacci word
t_valid  in  1  timer word valid
t_out  in  DATA_W  timer word
f_en  out  1  fibonacci produce enable
t_en  out  1  timer produce enable
data_1_en  out  1  wrapper write strobe
data_1  out  DATA_W  wrapper write data
grant  out  2  01 = fibonacci, 10 = timer, 00 = none
f_cnt  out  CW  fibonacci words forwarded this session
t_cnt  out  CW  timer words forwarded this session
done  out  1  one-cycle pulse on return to IDLE after stop
err  out  1  sticky: valid from a non-owner producer

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; f_en=t_en=data_1_en=0; grant=00.
  - f_cnt=t_cnt=0; done=err=0; burst_cnt=0.
  - owner=T and last=T, so the first grant goes to F.
  - Reset mid-burst aborts immediately; no drain.
- States: IDLE, GNT_F, GNT_T, SWITCH, DRAIN.
- IDLE:
  - If enable and (quota_f≠0 or quota_t≠0): clear f_cnt, t_cnt, err.
  - Grant the source other than last; if its quota is 0, grant the other source.
  - Otherwise stay in IDLE.
  - stop is ignored in IDLE.
- Grant entry: latch quota of the granted source into qlat; burst_cnt=0; owner=last=granted source.
- Enables:
  - f_en = (state==GNT_F) & ~buffer_full & ~(f_valid & burst_cnt==qlat-1).
  - t_en is symmetric.
  - These are combinational, so at most qlat words are produced per burst.
- Forwarding (combinational, zero latency):
  - data_1_en = (f_valid & owner==F) | (t_valid & owner==T).
  - data_1 = owner==T ? t_out : f_out.
  - Forwarding applies in GNT_x, SWITCH and DRAIN.
  - f_cnt/t_cnt increment on each forwarded word and wrap at 2^CW.
- Burst:
  - In GNT_x, a forwarded valid increments burst_cnt.
  - When burst_cnt reaches qlat, go to SWITCH.
  - buffer_full only drops the enable; state and burst_cnt hold (no timeout).
- SWITCH (1 cycle):
  - Late valid from owner is still forwarded.
  - Next state: GNT of the other source if its quota≠0, else the same source if its quota≠0.
  - If both quotas are 0 or enable=0, go to IDLE with no done pulse.
- stop in GNT_x or SWITCH → DRAIN. stop beats burst completion in the same cycle.
- DRAIN (1 cycle): enables low, late owner valid forwarded; then IDLE with done=1 for one cycle.
- Non-owner valid: not forwarded; sets err, which holds until reset or the next session start.
- enable falling during GNT_x: the current burst completes, then SWITCH → IDLE.
- grant = 01 in GNT_F, 10 in GNT_T, 00 otherwise.

Test Plan:
- Reset then enable=1, quota_f=3, quota_t=2, producers assert valid every cycle en is high → f_en for 3 words, SWITCH, t_en for 2 words, repeat; data_1 alternates sources; f_cnt=3, t_cnt=2 after the first round.
- quota_f=0, quota_t=4 → only GNT_T ever entered, f_en never 1; with both quotas 0, stays in IDLE, grant=00.
- buffer_full=1 for 5 cycles after the 2nd of 3 F words → f_en low, state GNT_F, burst_cnt=2 held; after release exactly 1 more word, then SWITCH.
- stop during GNT_T with a valid arriving the next cycle → DRAIN forwards that word (t_cnt+1), IDLE next, done high for exactly 1 cycle.
- t_valid pulse while grant=01 → data_1_en=0, err=1 and sticky; cleared at next session start.
- rst=0 mid-burst with f_valid high → next cycle all outputs at reset values, no done pulse; next enable grants F first.
